// File: rtl/ti_dac_serializer.sv
// Frame FIFO plus slot-ordered serializer that feeds one DAC with offset-binary codes.
// Optional build macro TI_DAC_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow event counter.

// Generic frame FIFO: one W-bit word per entry, pointers wrap modulo DEPTH (any DEPTH >= 2).
// Latency: a word written at edge k is visible at o_rdat after edge k.
// Backpressure: push is ignored when full and pop is ignored when empty; the caller watches o_count.
module ti_dac_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdat,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdat  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= wrap_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= wrap_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

// Serializes Nti-sample frames onto one DAC, slot 0 first, signed in / offset-binary out.
// Latency: frame accepted at edge k into an idle, empty block shows slot 0 after edge k+1.
// Backpressure: o_din_ready = buffered frames < DEPTH, from registered count only.
module ti_dac_serializer #(
    parameter int Ndac  = 8,
    parameter int Nti   = 5,
    parameter int DEPTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [Ndac-1:0]  i_din [Nti],
    input  logic                    i_din_valid,
    output logic                    o_din_ready,
    output logic [Ndac-1:0]         o_dout,
    output logic                    o_dout_valid,
    output logic [$clog2(Nti)-1:0]  o_slot,
    output logic                    o_frame_start,
    output logic                    o_underflow,
    input  logic                    i_clr_underflow
`ifdef TI_DAC_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]             o_underflow_cnt
`endif
);
    localparam int FW = Ndac * Nti;
    localparam int SW = $clog2(Nti);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [Ndac-1:0] MID = Ndac'(1) << (Ndac - 1);

    if (Nti < 2) begin : g_bad_nti
        $error("ti_dac_serializer: Nti must be >= 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("ti_dac_serializer: DEPTH must be >= 2");
    end

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FW-1:0]   w_din_packed;
    logic [FW-1:0]   w_head;
    logic [CW-1:0]   w_count;
    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic            w_shift;
    logic            w_last;
    logic            w_underflow_evt;
    logic [FW-1:0]   r_shift;
    logic [Ndac-1:0] r_dout;
    logic            r_dout_valid;
    logic [SW-1:0]   r_slot;
    logic            r_frame_start;
    logic            r_underflow;

    function automatic logic [Ndac-1:0] to_offset_bin(input logic [Ndac-1:0] s);
        return {~s[Ndac-1], s[Ndac-2:0]};
    endfunction

    // Slot 0 lands in the least significant lane so the frame drains by right shifts.
    for (genvar gi = 0; gi < Nti; gi++) begin : g_pack
        assign w_din_packed[gi*Ndac +: Ndac] = i_din[gi];
    end

    assign o_din_ready = (w_count < CW'(DEPTH));
    assign w_push      = i_din_valid && o_din_ready;
    assign w_last      = (r_slot == SW'(Nti - 1));

    ti_dac_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdat  (w_din_packed),
        .i_pop   (w_pop),
        .o_rdat  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        w_underflow_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_count != '0) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_last) begin
                    w_shift = 1'b1;
                end else if (w_count != '0) begin
                    w_pop  = 1'b1;
                    w_load = 1'b1;
                end else begin
                    w_state_nxt     = S_IDLE;
                    w_underflow_evt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Neither loading nor shifting means idle or just drained: park the DAC at mid-scale.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift       <= '0;
            r_dout        <= MID;
            r_dout_valid  <= 1'b0;
            r_slot        <= '0;
            r_frame_start <= 1'b0;
        end else if (w_load) begin
            r_shift       <= w_head >> Ndac;
            r_dout        <= to_offset_bin(w_head[Ndac-1:0]);
            r_dout_valid  <= 1'b1;
            r_slot        <= '0;
            r_frame_start <= 1'b1;
        end else if (w_shift) begin
            r_shift       <= r_shift >> Ndac;
            r_dout        <= to_offset_bin(r_shift[Ndac-1:0]);
            r_dout_valid  <= 1'b1;
            r_slot        <= r_slot + SW'(1);
            r_frame_start <= 1'b0;
        end else begin
            r_dout        <= MID;
            r_dout_valid  <= 1'b0;
            r_slot        <= '0;
            r_frame_start <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_underflow <= 1'b0;
        end else if (w_underflow_evt) begin
            r_underflow <= 1'b1;
        end else if (i_clr_underflow) begin
            r_underflow <= 1'b0;
        end
    end

`ifdef TI_DAC_UNDERFLOW_CNT_EN
    logic [15:0] r_underflow_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_underflow_cnt <= '0;
        end else if (i_clr_underflow) begin
            r_underflow_cnt <= w_underflow_evt ? 16'd1 : 16'd0;
        end else if (w_underflow_evt && (r_underflow_cnt != 16'hFFFF)) begin
            r_underflow_cnt <= r_underflow_cnt + 16'd1;
        end
    end

    assign o_underflow_cnt = r_underflow_cnt;
`endif

    assign o_dout        = r_dout;
    assign o_dout_valid  = r_dout_valid;
    assign o_slot        = r_slot;
    assign o_frame_start = r_frame_start;
    assign o_underflow   = r_underflow;
endmodule

// File: tb/tb_ti_dac_serializer.sv
// Directed bench for ti_dac_serializer (Ndac=8, Nti=5, DEPTH=2); TI_DAC_UNDERFLOW_CNT_EN aware.
module tb_ti_dac_serializer;
    localparam int NDAC  = 8;
    localparam int NTI   = 5;
    localparam int DEPTH = 2;

    logic                   clk;
    logic                   rst;
    logic signed [NDAC-1:0] din [NTI];
    logic                   din_valid;
    logic                   din_ready;
    logic [NDAC-1:0]        dout;
    logic                   dout_valid;
    logic [2:0]             slot;
    logic                   frame_start;
    logic                   underflow;
    logic                   clr_underflow;
`ifdef TI_DAC_UNDERFLOW_CNT_EN
    logic [15:0]            underflow_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] frames [4][NTI];

    ti_dac_serializer #(
        .Ndac  (NDAC),
        .Nti   (NTI),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_din           (din),
        .i_din_valid     (din_valid),
        .o_din_ready     (din_ready),
        .o_dout          (dout),
        .o_dout_valid    (dout_valid),
        .o_slot          (slot),
        .o_frame_start   (frame_start),
        .o_underflow     (underflow),
        .i_clr_underflow (clr_underflow)
`ifdef TI_DAC_UNDERFLOW_CNT_EN
        ,
        .o_underflow_cnt (underflow_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int f);
        for (int i = 0; i < NTI; i++) din[i] = frames[f][i];
    endtask

    task automatic pulse_clear;
        clr_underflow = 1'b1;
        tick;
        clr_underflow = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        din_valid = 1'b0;
        clr_underflow = 1'b0;
        for (int i = 0; i < NTI; i++) din[i] = '0;
        repeat (3) tick;
        tests++; if (dout !== 8'h80) begin fails++; $display("FAIL reset_dout got=%h exp=80", dout); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        tests++; if (slot !== 3'd0) begin fails++; $display("FAIL reset_slot got=%0d exp=0", slot); end
        tests++; if (din_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", din_ready); end
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
`ifdef TI_DAC_UNDERFLOW_CNT_EN
        tests++; if (underflow_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", underflow_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single_frame;
        logic [7:0] exp_code [NTI];
        exp_code = '{8'h00, 8'h7F, 8'h80, 8'h81, 8'hFF};
        din[0] = 8'sh80; din[1] = 8'shFF; din[2] = 8'sh00; din[3] = 8'sh01; din[4] = 8'sh7F;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL single_latency valid got=%b exp=0", dout_valid); end
        for (int i = 0; i < NTI; i++) begin
            tick;
            tests++; if (dout !== exp_code[i]) begin fails++; $display("FAIL single_dout[%0d] got=%h exp=%h", i, dout, exp_code[i]); end
            tests++; if (slot !== 3'(i)) begin fails++; $display("FAIL single_slot[%0d] got=%0d exp=%0d", i, slot, i); end
            tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL single_valid[%0d] got=%b exp=1", i, dout_valid); end
            tests++; if (frame_start !== (i == 0)) begin fails++; $display("FAIL single_fs[%0d] got=%b exp=%b", i, frame_start, (i == 0)); end
        end
        tick;
        tests++; if (dout !== 8'h80) begin fails++; $display("FAIL single_drain_dout got=%h exp=80", dout); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid got=%b exp=0", dout_valid); end
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL single_underflow got=%b exp=1", underflow); end
`ifdef TI_DAC_UNDERFLOW_CNT_EN
        tests++; if (underflow_cnt !== 16'd1) begin fails++; $display("FAIL single_cnt got=%0d exp=1", underflow_cnt); end
`endif
    endtask

    task automatic test_underflow_clear;
        pulse_clear;
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL clr_underflow got=%b exp=0", underflow); end
`ifdef TI_DAC_UNDERFLOW_CNT_EN
        tests++; if (underflow_cnt !== 16'd0) begin fails++; $display("FAIL clr_cnt got=%0d exp=0", underflow_cnt); end
`endif
        load_frame(0);
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        repeat (5) tick;
        tests++; if (slot !== 3'd4) begin fails++; $display("FAIL clr_pre_slot got=%0d exp=4", slot); end
        clr_underflow = 1'b1;
        tick;
        clr_underflow = 1'b0;
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL set_over_clear got=%b exp=1", underflow); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL set_over_clear_valid got=%b exp=0", dout_valid); end
`ifdef TI_DAC_UNDERFLOW_CNT_EN
        tests++; if (underflow_cnt !== 16'd1) begin fails++; $display("FAIL set_over_clear_cnt got=%0d exp=1", underflow_cnt); end
`endif
    endtask

    task automatic test_back_to_back;
        int  f = 0;
        int  nv = 0;
        bit  acc;
        bit  bubble = 1'b0;
        bit  uf_seen = 1'b0;
        logic [7:0] exp_code;
        pulse_clear;
        load_frame(0);
        din_valid = 1'b1;
        for (int c = 0; c < 30 && nv < 20; c++) begin
            acc = din_valid && din_ready;
            tick;
            if (acc) begin
                f++;
                if (f < 4) load_frame(f); else din_valid = 1'b0;
            end
            if (dout_valid) begin
                exp_code = frames[nv / 5][nv % 5] ^ 8'h80;
                tests++; if (dout !== exp_code) begin fails++; $display("FAIL b2b_dout[%0d] got=%h exp=%h", nv, dout, exp_code); end
                nv++;
            end else if (nv > 0) begin
                bubble = 1'b1;
            end
            if (underflow) uf_seen = 1'b1;
        end
        din_valid = 1'b0;
        tests++; if (nv !== 20) begin fails++; $display("FAIL b2b_count got=%0d exp=20", nv); end
        tests++; if (bubble !== 1'b0) begin fails++; $display("FAIL b2b_bubble got=%b exp=0", bubble); end
        tests++; if (uf_seen !== 1'b0) begin fails++; $display("FAIL b2b_early_underflow got=%b exp=0", uf_seen); end
        tick;
        tests++; if (dout_valid !== 1'b0 || underflow !== 1'b1) begin
            fails++; $display("FAIL b2b_drain valid=%b underflow=%b exp valid=0 underflow=1", dout_valid, underflow);
        end
    endtask

    task automatic test_backpressure;
        int  f = 0;
        int  acc_c [4];
        bit  acc;
        bit  rdy_full = 1'b1;
        bit  rdy_at_pop = 1'b1;
        logic [7:0] rec_dout [21];
        logic [2:0] rec_slot [21];
        logic [7:0] exp_code;
        int  exp_acc [4];
        exp_acc = '{0, 1, 2, 7};
        for (int i = 0; i < 4; i++) acc_c[i] = -1;
        pulse_clear;
        load_frame(0);
        din_valid = 1'b1;
        for (int c = 0; c < 21; c++) begin
            if (c == 6) rdy_at_pop = din_ready;
            acc = din_valid && din_ready;
            tick;
            if (acc) begin
                acc_c[f] = c;
                f++;
                if (f < 4) load_frame(f); else din_valid = 1'b0;
            end
            if (c == 2) rdy_full = din_ready;
            rec_dout[c] = dout;
            rec_slot[c] = slot;
        end
        din_valid = 1'b0;
        tests++; if (rdy_full !== 1'b0) begin fails++; $display("FAIL bp_full_ready got=%b exp=0", rdy_full); end
        tests++; if (rdy_at_pop !== 1'b0) begin fails++; $display("FAIL bp_ready_in_pop_cycle got=%b exp=0", rdy_at_pop); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (acc_c[i] !== exp_acc[i]) begin fails++; $display("FAIL bp_accept[%0d] got=%0d exp=%0d", i, acc_c[i], exp_acc[i]); end
        end
        for (int i = 0; i < NTI; i++) begin
            exp_code = frames[3][i] ^ 8'h80;
            tests++; if (rec_dout[16 + i] !== exp_code || rec_slot[16 + i] !== 3'(i)) begin
                fails++; $display("FAIL bp_blocked_frame[%0d] dout=%h slot=%0d exp dout=%h slot=%0d", i, rec_dout[16 + i], rec_slot[16 + i], exp_code, i);
            end
        end
        tick;
        pulse_clear;
    endtask

    task automatic test_reset_midframe;
        bit stale = 1'b0;
        logic [7:0] exp_code;
        pulse_clear;
        load_frame(0);
        din_valid = 1'b1;
        tick;
        load_frame(1);
        tick;
        din_valid = 1'b0;
        repeat (2) tick;
        exp_code = frames[0][2] ^ 8'h80;
        tests++; if (slot !== 3'd2 || dout !== exp_code) begin
            fails++; $display("FAIL mid_pre slot=%0d dout=%h exp slot=2 dout=%h", slot, dout, exp_code);
        end
        rst = 1'b1;
        tick;
        tests++; if (dout !== 8'h80) begin fails++; $display("FAIL mid_rst_dout got=%h exp=80", dout); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0", dout_valid); end
        tests++; if (slot !== 3'd0) begin fails++; $display("FAIL mid_rst_slot got=%0d exp=0", slot); end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (dout_valid) stale = 1'b1;
        end
        tests++; if (stale !== 1'b0) begin fails++; $display("FAIL mid_stale got=%b exp=0", stale); end
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL mid_underflow got=%b exp=0", underflow); end
        tests++; if (din_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got=%b exp=1", din_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frames[0] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
        frames[1] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4};
        frames[2] = '{8'h05, 8'h7E, 8'h81, 8'hFE, 8'h00};
        frames[3] = '{8'h6A, 8'h95, 8'h3C, 8'hC7, 8'h18};
        test_reset;
        test_single_frame;
        test_underflow_clear;
        test_back_to_back;
        test_backpressure;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
